// File: rtl/pending_priority_encoder_pkg.sv
// Shared definitions for the pending priority encoder: default width, clog2 helper
// and reset values. Optional feature macro used by this block: ROUND_ROBIN_EN.
package pending_priority_encoder_pkg;

  localparam int DEF_N = 4;

  localparam logic RST_VALID   = 1'b0;
  localparam logic RST_OVERRUN = 1'b0;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pending_priority_encoder_prio_select.sv
// Combinational selector: finds the first set bit of i_vec searching downward from
// i_start with wrap-around; o_any reports whether any bit is set.
module prio_select
  import pending_priority_encoder_pkg::*;
#(
  parameter  int N  = DEF_N,
  localparam int CW = clog2_f(N)
) (
  input  logic [N-1:0]  i_vec,
  input  logic [CW-1:0] i_start,
  output logic          o_any,
  output logic [CW-1:0] o_idx
);

  logic [CW-1:0] w_pos;
  logic          w_found;

  always_comb begin
    o_any   = |i_vec;
    o_idx   = '0;
    w_pos   = '0;
    w_found = 1'b0;
    // N is a power of two, so CW-bit subtraction gives the modulo wrap for free
    for (int k = 0; k < N; k++) begin
      w_pos = i_start - CW'(k);
      if (!w_found && i_vec[w_pos]) begin
        w_found = 1'b1;
        o_idx   = w_pos;
      end
    end
  end

endmodule

// File: rtl/pending_priority_encoder.sv
// Sticky-pending N:log2(N) priority encoder with valid/ready token output.
// Define ROUND_ROBIN_EN to rotate the search start past the last granted line.
module pending_priority_encoder
  import pending_priority_encoder_pkg::*;
#(
  parameter  int N  = DEF_N,
  localparam int CW = clog2_f(N)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          En,
  input  logic [N-1:0]  Req,
  input  logic          Ready,
  output logic          Valid,
  output logic [CW-1:0] Code,
  output logic [N-1:0]  Pending,
  output logic          Overrun
);

  logic [N-1:0]  r_pending;
  logic          r_valid;
  logic [CW-1:0] r_code;
  logic          r_overrun;

  logic [N-1:0]  w_set;
  logic [N-1:0]  w_clr;
  logic          w_load;
  logic          w_any;
  logic [CW-1:0] w_idx;
  logic [CW-1:0] w_start;

`ifdef ROUND_ROBIN_EN
  logic [CW-1:0] r_ptr;
  assign w_start = r_ptr - CW'(1);
`else
  assign w_start = CW'(N - 1);
`endif

  assign w_set  = Req & {N{En}};
  assign w_load = !r_valid || Ready;

  prio_select #(.N(N)) u_sel (
    .i_vec   (r_pending),
    .i_start (w_start),
    .o_any   (w_any),
    .o_idx   (w_idx)
  );

  always_comb begin
    w_clr = '0;
    if (w_load && w_any) w_clr[w_idx] = 1'b1;
  end

  // set wins over clear, so a re-request of the line just granted stays pending
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_pending <= '0;
      r_valid   <= RST_VALID;
      r_code    <= '0;
      r_overrun <= RST_OVERRUN;
`ifdef ROUND_ROBIN_EN
      r_ptr     <= '0;
`endif
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_overrun <= |(w_set & r_pending & ~w_clr);
      if (w_load) begin
        if (w_any) begin
          r_valid <= 1'b1;
          r_code  <= w_idx;
`ifdef ROUND_ROBIN_EN
          r_ptr   <= w_idx;
`endif
        end else begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign Valid   = r_valid;
  assign Code    = r_code;
  assign Pending = r_pending;
  assign Overrun = r_overrun;

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Testbench for pending_priority_encoder (N=4): directed scenarios plus random
// traffic, all checked against a behavioural token model.
module tb_pending_priority_encoder;

  localparam int N = 4;

  logic       Clk;
  logic       Rst;
  logic       En;
  logic [3:0] Req;
  logic       Ready;
  logic       Valid;
  logic [1:0] Code;
  logic [3:0] Pending;
  logic       Overrun;

  int n_checks;
  int n_fail;

  // behavioural model state
  int m_pend;
  int m_valid;
  int m_code;
  int m_ptr;
  int m_ovr;

  pending_priority_encoder #(.N(N)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .En      (En),
    .Req     (Req),
    .Ready   (Ready),
    .Valid   (Valid),
    .Code    (Code),
    .Pending (Pending),
    .Overrun (Overrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Model: grant the first pending line walking downward from the start index.
  task automatic model_step(input int rst, input int en, input int req, input int rdy);
    int set, clr, start, line;
    if (rst != 0) begin
      m_pend = 0; m_valid = 0; m_code = 0; m_ptr = 0; m_ovr = 0;
      return;
    end
    set = (en != 0) ? req : 0;
    clr = 0;
    if (m_valid == 0 || rdy != 0) begin
      if (m_pend != 0) begin
`ifdef ROUND_ROBIN_EN
        start = (m_ptr + N - 1) % N;
`else
        start = N - 1;
`endif
        line = -1;
        for (int k = 0; k < N; k++) begin
          if (line < 0 && ((m_pend >> ((start - k + N) % N)) & 1) == 1)
            line = (start - k + N) % N;
        end
        m_valid = 1;
        m_code  = line;
        m_ptr   = line;
        clr     = 1 << line;
      end else begin
        m_valid = 0;
      end
    end
    m_ovr  = ((set & m_pend & ~clr) != 0) ? 1 : 0;
    m_pend = (m_pend & ~clr) | set;
  endtask

  task automatic tick(input int rst, input int en, input int req, input int rdy);
    Rst   = (rst != 0);
    En    = (en != 0);
    Req   = 4'(req);
    Ready = (rdy != 0);
    @(posedge Clk);
    model_step(rst, en, req, rdy);
    #1;
    check_eq("valid",   int'(Valid),   m_valid);
    if (m_valid != 0) check_eq("code", int'(Code), m_code);
    check_eq("pending", int'(Pending), m_pend);
    check_eq("overrun", int'(Overrun), m_ovr);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_pend = 0; m_valid = 0; m_code = 0; m_ptr = 0; m_ovr = 0;
    Rst = 1'b1; En = 1'b1; Req = '0; Ready = 1'b1;

    // reset state
    tick(1, 1, 0, 1);
    check_eq("rst_valid", int'(Valid), 0);
    check_eq("rst_code",  int'(Code),  0);
    check_eq("rst_pend",  int'(Pending), 0);

    // 1: Req=0101 one cycle, Ready=1
    tick(0, 1, 4'b0101, 1);
    check_eq("t1_valid_t1", int'(Valid), 0);
    tick(0, 1, 0, 1);
    check_eq("t1_code2", int'(Code), 2);
    check_eq("t1_valid2", int'(Valid), 1);
    tick(0, 1, 0, 1);
    check_eq("t1_code0", int'(Code), 0);
    tick(0, 1, 0, 1);
    check_eq("t1_drained", int'(Valid), 0);

    // 2: stall with Code=3, Req=0010 during stall
    tick(0, 1, 4'b1000, 0);
    tick(0, 1, 4'b0010, 0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 0, 0);
      check_eq("t2_hold_code", int'(Code), 3);
      check_eq("t2_hold_valid", int'(Valid), 1);
    end
    check_eq("t2_pend", int'(Pending), 4'b0010);
    tick(0, 1, 0, 1);
    check_eq("t2_next_code", int'(Code), 1);
    tick(0, 1, 0, 1);
    check_eq("t2_drained", int'(Valid), 0);

    // 3: duplicate request while pending and stalled
    tick(0, 1, 4'b1000, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 4'b0001, 0);
    tick(0, 1, 4'b0001, 0);
    check_eq("t3_overrun", int'(Overrun), 1);
    tick(0, 1, 0, 0);
    check_eq("t3_ovr_pulse", int'(Overrun), 0);
    tick(0, 1, 0, 1);
    check_eq("t3_tok0", int'(Code), 0);
    tick(0, 1, 0, 1);
    check_eq("t3_single", int'(Valid), 0);

    // 4: capture disabled
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 4'b1111, 1);
      check_eq("t4_pend", int'(Pending), 0);
      check_eq("t4_valid", int'(Valid), 0);
      check_eq("t4_ovr", int'(Overrun), 0);
    end

    // 5: reset while holding a token and pending lines
    tick(0, 1, 4'b1110, 0);
    tick(0, 1, 4'b0000, 0);
    tick(0, 1, 4'b1000, 0);
    check_eq("t5_pend_pre", int'(Pending), 4'b1110);
    tick(1, 1, 0, 0);
    check_eq("t5_valid", int'(Valid), 0);
    check_eq("t5_code",  int'(Code), 0);
    check_eq("t5_pend",  int'(Pending), 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 1);
      check_eq("t5_no_tok", int'(Valid), 0);
    end

    // 6: all lines held requesting, Ready=1
    tick(0, 1, 4'b1111, 1);
    for (int k = 0; k < 8; k++) begin
      tick(0, 1, 4'b1111, 1);
`ifdef ROUND_ROBIN_EN
      check_eq("t6_rr_code", int'(Code), (3 - (k % 4)));
`else
      check_eq("t6_fixed_code", int'(Code), 3);
`endif
    end
    tick(1, 1, 0, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 49) == 0) ? 1 : 0,
           ($urandom_range(0, 7) != 0) ? 1 : 0,
           ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : 0,
           int'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
